// File: rtl/ahb_sched_pkg.sv
// Shared types for the AHB transfer scheduler.
//   state_t    : scheduler FSM states
//   grant_t    : which requester last owned the AHB master
//   WORD_BYTES : byte stride between consecutive words
//   GNT_RD/WR  : bit positions in the one-hot grant vector
package ahb_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        RD_ISSUE,
        RD_WAIT,
        WR_ISSUE,
        WR_WAIT,
        FINISH,
        ERR
    } state_t;

    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } grant_t;

    localparam int WORD_BYTES = 4;
    localparam int GNT_RD     = 0;
    localparam int GNT_WR     = 1;

endpackage

// File: rtl/ahb_xfer_scheduler_arb.sv
// rr_arb2: two-requester round-robin arbiter (purely combinational).
//   rd_elig, wr_elig : eligibility of the read and write requesters
//   last_grant       : owner of the previous grant
//   grant            : one-hot grant, bit GNT_RD = read, bit GNT_WR = write
module rr_arb2
    import ahb_sched_pkg::*;
(
    input  logic       rd_elig,
    input  logic       wr_elig,
    input  grant_t     last_grant,
    output logic [1:0] grant
);

    always_comb begin
        // NOTE: default assignment first so no path through the block leaves
        // grant unassigned, which would infer a latch.
        grant = 2'b00;
        if (rd_elig && wr_elig) begin
            // Contention: hand the master to whoever did not have it last.
            grant[GNT_RD] = (last_grant == WRITE);
            grant[GNT_WR] = (last_grant == READ);
        end else begin
            grant[GNT_RD] = rd_elig;
            grant[GNT_WR] = wr_elig;
        end
    end

endmodule

// File: rtl/ahb_xfer_scheduler.sv
// ahb_xfer_scheduler: shares one AHB master between the greyscale fetch path
// (reads) and the buffer2 write-back path (writes) for one frame.
//   clk, rst                : clock, synchronous active-high reset
//   start                   : begin a frame (honoured in IDLE or ERR only)
//   rd_base, wr_base        : first read / write byte address, sampled on start
//   frame_words             : words to read and to write, sampled on start
//   rd_req, wr_req          : fetch buffer has space / buffer2 holds a word
//   read_complete           : AHB master finished the outstanding read
//   write_complete          : AHB master finished the outstanding write
//   re, we                  : one-cycle request pulses to the AHB master
//   mcu_raddr, mcu_waddr    : addresses, held from issue until completion
//   rd_done, wr_done        : one-cycle completion pulses to the requesters
//   busy, done, err         : frame active / end-of-frame pulse / sticky timeout
module ahb_xfer_scheduler
    import ahb_sched_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] rd_base,
    input  logic [ADDR_W-1:0] wr_base,
    input  logic [CNT_W-1:0]  frame_words,
    input  logic              rd_req,
    input  logic              wr_req,
    input  logic              read_complete,
    input  logic              write_complete,
    output logic              re,
    output logic              we,
    output logic [ADDR_W-1:0] mcu_raddr,
    output logic [ADDR_W-1:0] mcu_waddr,
    output logic              rd_done,
    output logic              wr_done,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    state_t             state;
    grant_t             last_grant;
    logic [ADDR_W-1:0]  rd_base_q;
    logic [ADDR_W-1:0]  wr_base_q;
    logic [CNT_W-1:0]   frame_words_q;
    logic [CNT_W-1:0]   rd_cnt;
    logic [CNT_W-1:0]   wr_cnt;
    logic [WAIT_W-1:0]  wait_cnt;
    logic               rd_elig;
    logic               wr_elig;
    logic [1:0]         grant;
    logic               wait_expired;

    // A write may only go out for a word that has already been read.
    assign rd_elig = rd_req && (rd_cnt < frame_words_q);
    assign wr_elig = wr_req && (wr_cnt < frame_words_q) && (wr_cnt < rd_cnt);

    // wait_cnt counts completed wait cycles; this is the TIMEOUT-th one.
    assign wait_expired = (wait_cnt == WAIT_W'(TIMEOUT - 1));

    rr_arb2 u_arb (
        .rd_elig    (rd_elig),
        .wr_elig    (wr_elig),
        .last_grant (last_grant),
        .grant      (grant)
    );

    // Every output is set on the edge that enters the state owning it, so
    // re/we are high exactly while the FSM sits in the matching ISSUE state.
    always_ff @(posedge clk) begin
        if (rst) begin
            // Configuration registers are reset too, so no X can reach the
            // address adders even before the first start.
            state         <= IDLE;
            last_grant    <= WRITE;
            rd_base_q     <= '0;
            wr_base_q     <= '0;
            frame_words_q <= '0;
            rd_cnt        <= '0;
            wr_cnt        <= '0;
            wait_cnt      <= '0;
            re            <= 1'b0;
            we            <= 1'b0;
            mcu_raddr     <= '0;
            mcu_waddr     <= '0;
            rd_done       <= 1'b0;
            wr_done       <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only, so
            // every read in this block sees the pre-edge value.
            re      <= 1'b0;
            we      <= 1'b0;
            rd_done <= 1'b0;
            wr_done <= 1'b0;
            done    <= 1'b0;

            case (state)
                IDLE, ERR: begin
                    if (start) begin
                        rd_base_q     <= rd_base;
                        wr_base_q     <= wr_base;
                        frame_words_q <= frame_words;
                        rd_cnt        <= '0;
                        wr_cnt        <= '0;
                        err           <= 1'b0;
                        busy          <= 1'b1;
                        state         <= ARB;
                    end
                end

                ARB: begin
                    if (grant[GNT_RD]) begin
                        last_grant <= READ;
                        re         <= 1'b1;
                        mcu_raddr  <= rd_base_q + ADDR_W'(rd_cnt) * ADDR_W'(WORD_BYTES);
                        state      <= RD_ISSUE;
                    end else if (grant[GNT_WR]) begin
                        last_grant <= WRITE;
                        we         <= 1'b1;
                        mcu_waddr  <= wr_base_q + ADDR_W'(wr_cnt) * ADDR_W'(WORD_BYTES);
                        state      <= WR_ISSUE;
                    end else if (rd_cnt == frame_words_q && wr_cnt == frame_words_q) begin
                        done  <= 1'b1;
                        state <= FINISH;
                    end
                end

                RD_ISSUE: begin
                    wait_cnt <= '0;
                    state    <= RD_WAIT;
                end

                RD_WAIT: begin
                    if (read_complete) begin
                        rd_done <= 1'b1;
                        rd_cnt  <= rd_cnt + CNT_W'(1);
                        state   <= ARB;
                    end else if (wait_expired) begin
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        state <= ERR;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end

                WR_ISSUE: begin
                    wait_cnt <= '0;
                    state    <= WR_WAIT;
                end

                WR_WAIT: begin
                    if (write_complete) begin
                        wr_done <= 1'b1;
                        wr_cnt  <= wr_cnt + CNT_W'(1);
                        state   <= ARB;
                    end else if (wait_expired) begin
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        state <= ERR;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end

                FINISH: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_xfer_scheduler.sv
// Directed self-checking bench for ahb_xfer_scheduler. A small responder plays
// the AHB master (optional completion 3 edges after each issue); a monitor logs
// every issued transfer and counts pulses.
module tb_ahb_xfer_scheduler;

    localparam int ADDR_W  = 32;
    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 8;

    logic              tb_clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] rd_base;
    logic [ADDR_W-1:0] wr_base;
    logic [CNT_W-1:0]  frame_words;
    logic              rd_req;
    logic              wr_req;
    logic              read_complete;
    logic              write_complete;
    logic              re;
    logic              we;
    logic [ADDR_W-1:0] mcu_raddr;
    logic [ADDR_W-1:0] mcu_waddr;
    logic              rd_done;
    logic              wr_done;
    logic              busy;
    logic              done;
    logic              err;

    // Completion sources: automatic responder OR manual pulses from the sequence.
    logic auto_rc = 1'b0, auto_wc = 1'b0;
    logic man_rc, man_wc;
    bit   auto_rd, auto_wr;
    int   rd_cd = 0, wr_cd = 0;

    assign read_complete  = auto_rc | man_rc;
    assign write_complete = auto_wc | man_wc;

    // Monitor state
    logic              log_kind[$];   // 0 = read, 1 = write
    logic [ADDR_W-1:0] log_addr[$];
    int n_rd_done = 0, n_wr_done = 0, n_done = 0, n_overlap = 0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 tb_clk = ~tb_clk;

    ahb_xfer_scheduler #(
        .ADDR_W  (ADDR_W),
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk            (tb_clk),
        .rst            (rst),
        .start          (start),
        .rd_base        (rd_base),
        .wr_base        (wr_base),
        .frame_words    (frame_words),
        .rd_req         (rd_req),
        .wr_req         (wr_req),
        .read_complete  (read_complete),
        .write_complete (write_complete),
        .re             (re),
        .we             (we),
        .mcu_raddr      (mcu_raddr),
        .mcu_waddr      (mcu_waddr),
        .rd_done        (rd_done),
        .wr_done        (wr_done),
        .busy           (busy),
        .done           (done),
        .err            (err)
    );

    // Responder: completion is sampled on the third rising edge after the
    // cycle in which re/we was seen high.
    always @(negedge tb_clk) begin
        auto_rc = 1'b0;
        auto_wc = 1'b0;
        if (rd_cd > 0) begin
            rd_cd = rd_cd - 1;
            if (rd_cd == 0) auto_rc = 1'b1;
        end
        if (wr_cd > 0) begin
            wr_cd = wr_cd - 1;
            if (wr_cd == 0) auto_wc = 1'b1;
        end
        if (re && auto_rd) rd_cd = 2;
        if (we && auto_wr) wr_cd = 2;
    end

    always @(negedge tb_clk) begin
        if (re) begin log_kind.push_back(1'b0); log_addr.push_back(mcu_raddr); end
        if (we) begin log_kind.push_back(1'b1); log_addr.push_back(mcu_waddr); end
        if (re && we) n_overlap++;
        if (rd_done)  n_rd_done++;
        if (wr_done)  n_wr_done++;
        if (done)     n_done++;
    end

    // Inputs change and outputs are checked 1 ns after the falling edge.
    task automatic step(input int n);
        repeat (n) begin
            @(negedge tb_clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_xfer(input string tag, input int idx, input logic kind,
                              input logic [ADDR_W-1:0] addr);
        if (idx < log_kind.size()) begin
            check({tag, "_kind"}, 64'(log_kind[idx]), 64'(kind));
            check({tag, "_addr"}, 64'(log_addr[idx]), 64'(addr));
        end else begin
            check({tag, "_present"}, 64'(log_kind.size()), 64'(idx + 1));
        end
    endtask

    task automatic pulse_start(input logic [ADDR_W-1:0] rb, input logic [ADDR_W-1:0] wb,
                               input logic [CNT_W-1:0] fw);
        rd_base     = rb;
        wr_base     = wb;
        frame_words = fw;
        start       = 1'b1;
        step(1);
        start       = 1'b0;
    endtask

    // Steps until done is seen; timing out counts as a failed comparison.
    task automatic wait_done(input string tag, input int budget);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step(1);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_done_seen"}, 64'(seen), 64'(1));
    endtask

    initial begin
        int lb, db, rdb, wdb;

        rst = 1'b1; start = 1'b0; rd_base = '0; wr_base = '0; frame_words = '0;
        rd_req = 1'b0; wr_req = 1'b0; man_rc = 1'b0; man_wc = 1'b0;
        auto_rd = 1'b0; auto_wr = 1'b0;
        step(3);
        rst = 1'b0;

        // Reset state
        check("reset_ctrl", 64'({re, we, rd_done, wr_done, busy, done, err}), 64'(0));
        check("reset_raddr", 64'(mcu_raddr), 64'(0));
        check("reset_waddr", 64'(mcu_waddr), 64'(0));

        // 1: four-word frame, both requesters always ready -> R,W,R,W,...
        auto_rd = 1'b1; auto_wr = 1'b1; rd_req = 1'b1; wr_req = 1'b1;
        lb = log_kind.size(); db = n_done;
        pulse_start(32'h1000, 32'h2000, 16'd4);
        check("t1_busy_after_start", 64'(busy), 64'(1));
        wait_done("t1", 200);
        check("t1_xfer_count", 64'(log_kind.size() - lb), 64'(8));
        for (int i = 0; i < 4; i++) begin
            check_xfer("t1_rd", lb + 2 * i,     1'b0, 32'h1000 + 32'(4 * i));
            check_xfer("t1_wr", lb + 2 * i + 1, 1'b1, 32'h2000 + 32'(4 * i));
        end
        step(1);
        check("t1_one_done", 64'(n_done - db), 64'(1));
        check("t1_idle_busy", 64'(busy), 64'(0));

        // 2: writer ready but nothing read yet -> no write; then one read, one write
        rd_req = 1'b0; wr_req = 1'b1;
        lb = log_kind.size();
        pulse_start(32'h0100, 32'h0200, 16'd1);
        step(10);
        check("t2_no_write", 64'(log_kind.size() - lb), 64'(0));
        check("t2_busy_held", 64'(busy), 64'(1));
        rd_req = 1'b1;
        wait_done("t2", 100);
        check("t2_xfer_count", 64'(log_kind.size() - lb), 64'(2));
        check_xfer("t2_rd", lb,     1'b0, 32'h0100);
        check_xfer("t2_wr", lb + 1, 1'b1, 32'h0200);
        step(2);

        // 3: empty frame -> done two edges after start, no traffic
        lb = log_kind.size(); rdb = n_rd_done; wdb = n_wr_done;
        pulse_start(32'h0900, 32'h0a00, 16'd0);
        check("t3_busy", 64'(busy), 64'(1));
        check("t3_done_early", 64'(done), 64'(0));
        step(1);
        check("t3_done", 64'(done), 64'(1));
        step(1);
        check("t3_done_pulse", 64'({done, busy}), 64'(0));
        check("t3_no_xfer", 64'(log_kind.size() - lb), 64'(0));
        check("t3_no_cpl", 64'((n_rd_done - rdb) + (n_wr_done - wdb)), 64'(0));

        // 4: read completion withheld -> err after TIMEOUT wait cycles
        auto_rd = 1'b0;
        lb = log_kind.size();
        pulse_start(32'h4000, 32'h5000, 16'd2);
        step(1);
        check("t4_re", 64'(re), 64'(1));
        check("t4_raddr", 64'(mcu_raddr), 64'h4000);
        step(8);
        check("t4_err_before", 64'({err, busy}), 64'b01);
        step(1);
        check("t4_err", 64'({err, busy}), 64'b10);
        step(5);
        check("t4_err_sticky", 64'(err), 64'(1));
        check("t4_single_re", 64'(log_kind.size() - lb), 64'(1));
        auto_rd = 1'b1;
        lb = log_kind.size();
        pulse_start(32'h4000, 32'h5000, 16'd2);
        check("t4_err_cleared", 64'({err, busy}), 64'b01);
        wait_done("t4", 100);
        check("t4_restart_count", 64'(log_kind.size() - lb), 64'(4));
        check_xfer("t4_restart_rd", lb, 1'b0, 32'h4000);
        step(2);

        // 5: reset in RD_WAIT aborts; next frame starts from new base
        auto_rd = 1'b0;
        rdb = n_rd_done;
        pulse_start(32'h6000, 32'h7000, 16'd3);
        step(3);
        rst = 1'b1;
        step(1);
        check("t5_rst_ctrl", 64'({re, we, rd_done, wr_done, busy, done, err}), 64'(0));
        check("t5_rst_addr", {mcu_raddr, mcu_waddr}, 64'(0));
        rst = 1'b0;
        step(1);
        check("t5_no_rd_done", 64'(n_rd_done - rdb), 64'(0));
        auto_rd = 1'b1;
        pulse_start(32'h3000, 32'h3800, 16'd1);
        step(1);
        check("t5_re", 64'(re), 64'(1));
        check("t5_raddr", 64'(mcu_raddr), 64'h3000);
        wait_done("t5", 100);
        step(2);

        // 6: stray write_complete and start while busy are ignored
        auto_rd = 1'b0;
        lb = log_kind.size(); rdb = n_rd_done; wdb = n_wr_done; db = n_done;
        pulse_start(32'h7000, 32'h8000, 16'd2);
        step(2);
        man_wc = 1'b1;
        step(1);
        man_wc = 1'b0;
        pulse_start(32'hdead0000, 32'hbeef0000, 16'd9);
        step(2);
        check("t6_no_cpl", 64'((n_rd_done - rdb) + (n_wr_done - wdb)), 64'(0));
        check("t6_busy", 64'(busy), 64'(1));
        check("t6_raddr_held", 64'(mcu_raddr), 64'h7000);
        check("t6_single_issue", 64'(log_kind.size() - lb), 64'(1));
        auto_rd = 1'b1;
        man_rc = 1'b1;
        step(1);
        man_rc = 1'b0;
        check("t6_rd_done", 64'(rd_done), 64'(1));
        wait_done("t6", 100);
        check("t6_xfer_count", 64'(log_kind.size() - lb), 64'(4));
        check_xfer("t6_x0", lb,     1'b0, 32'h7000);
        check_xfer("t6_x1", lb + 1, 1'b1, 32'h8000);
        check_xfer("t6_x2", lb + 2, 1'b0, 32'h7004);
        check_xfer("t6_x3", lb + 3, 1'b1, 32'h8004);
        step(1);
        check("t6_one_done", 64'(n_done - db), 64'(1));

        check("no_re_we_overlap", 64'(n_overlap), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ahb_xfer_scheduler.md
Name: ahb_xfer_scheduler

Overview:
Sequences the AHB master interface for one frame of edge detection. Two requesters share the single master: the greyscale fetch path (reads) and the buffer2 write-back path (writes). The block arbitrates between them round-robin and drives re/we and mcu_raddr/mcu_waddr to the master. It consumes read_complete/write_complete from the master and counts words against a programmed frame length.

Parameters:
ADDR_W, 32, width of the address and base-address buses
CNT_W, 16, width of the word counters and of frame_words
TIMEOUT, 255, maximum cycles spent in a wait state before err is raised

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; begins a frame; ignored unless in IDLE or ERR
rd_base  in  ADDR_W  byte address of the first source word; sampled on start
wr_base  in  ADDR_W  byte address of the first result word; sampled on start
frame_words  in  CNT_W  number of words to read and to write; sampled on start
rd_req  in  1  fetch buffer has space for one word
wr_req  in  1  buffer2 holds one result word
read_complete  in  1  from AHB master; read data valid on greyscale_data
write_complete  in  1  from AHB master; write finished
re  out  1  one-cycle read request to the AHB master
we  out  1  one-cycle write request to the AHB master
mcu_raddr  out  ADDR_W  read address; held from issue until completion
mcu_waddr  out  ADDR_W  write address; held from issue until completion
rd_done  out  1  one-cycle pulse; fetch side captures greyscale_data
wr_done  out  1  one-cycle pulse; buffer2 pops its word
busy  out  1  high in every state except IDLE and ERR
done  out  1  one-cycle pulse at end of frame
err  out  1  sticky timeout flag

Behaviour:
- Reset: state=IDLE; rd_cnt=wr_cnt=0; last_grant=WRITE; all outputs 0.
- Reset while any transfer is in flight aborts the frame with no completion pulse. The AHB master is reset separately.
- States: IDLE, ARB, RD_ISSUE, RD_WAIT, WR_ISSUE, WR_WAIT, FINISH, ERR. All outputs are registered.
- IDLE/ERR, start=1:
  - latch rd_base, wr_base and frame_words; clear both counters; clear err; go to ARB.
- ARB:
  - rd_elig = rd_req && rd_cnt<frame_words.
  - wr_elig = wr_req && wr_cnt<frame_words && wr_cnt<rd_cnt. Writes can never outrun reads.
  - Both eligible: grant the opposite of last_grant. Because last_grant resets to WRITE, the first grant is always a read.
  - Exactly one eligible: grant it.
  - A grant updates last_grant and moves to RD_ISSUE or WR_ISSUE.
  - Neither eligible and rd_cnt==wr_cnt==frame_words: go to FINISH.
  - Neither eligible otherwise: stay in ARB.
- RD_ISSUE:
  - re=1 for exactly this cycle; mcu_raddr = rd_base + 4*rd_cnt (modulo 2^ADDR_W); go to RD_WAIT.
- RD_WAIT:
  - On read_complete: rd_done=1 for the next cycle, rd_cnt+1, go to ARB.
  - write_complete in this state is ignored.
- WR_ISSUE and WR_WAIT mirror RD_ISSUE and RD_WAIT:
  - we, mcu_waddr = wr_base + 4*wr_cnt, wr_done, wr_cnt.
  - read_complete is ignored in WR_WAIT.
- Timeout: a wait counter clears on each ISSUE. When it reaches TIMEOUT in a WAIT state: go to ERR, set err=1, busy=0. Counters are frozen. Only start or rst leaves ERR.
- FINISH: done=1 for one cycle, then IDLE.
- Invariants:
  - re and we are never high together; there is at most one outstanding transfer.
  - Addresses stay stable until the matching completion.
  - start outside IDLE/ERR has no effect.
- Latency:
  - start sampled at edge N → busy at N+1 → earliest re at N+2.
  - Completion sampled at edge M → rd_done/wr_done at M+1 → next issue no earlier than M+2.
- frame_words=0: ARB goes directly to FINISH; done is high 2 cycles after start is sampled, and no re/we is issued.

Decomposition:
- Package ahb_sched_pkg:
  - state_t enum
  - grant_t enum {READ, WRITE}
  - WORD_BYTES=4 constant
- Sub-module rr_arb2: two-requester round-robin arbiter.
  - Inputs: two eligibility bits and last_grant.
  - Outputs: one-hot grant.

Test Plan:
1. frame_words=4, rd_base=0x1000, wr_base=0x2000, rd_req=wr_req=1, completions 3 cycles after each issue → transfer order R,W,R,W,R,W,R,W; mcu_raddr 0x1000/04/08/0C; mcu_waddr 0x2000/04/08/0C; exactly one done pulse after the 8th completion.
2. After start, rd_req=0 and wr_req=1 → we never asserted, busy=1. Then raise rd_req → one read, then one write.
3. frame_words=0 → done pulse 2 cycles after start; re, we, rd_done and wr_done stay 0 throughout.
4. TIMEOUT=8, read_complete withheld → err=1 and busy=0 after 8 wait cycles, no further re. A new start clears err and restarts at rd_base.
5. rst during RD_WAIT → next cycle all outputs 0. A later start with rd_base=0x3000 issues re with mcu_raddr=0x3000.
6. write_complete pulsed during RD_WAIT, start pulsed while busy → no rd_done, no wr_done, counts unchanged; the frame completes normally.
